llsc_monitor: RTL
=================

// Module: llsc_monitor
// PURPOSE
//   Multi-channel LL/SC reservation monitor; parametrised successor of the single LLbit register.
//   Per channel: holds an LLbit, a reserved granule address and an expiry counter.
//   Grants or denies SC in the MEM stage. Cross-channel stores/SCs to a reserved granule break it.
//   Sits beside the memory stage; channels are harts or store ports sharing one data memory.
// PARAMETERS
//   NUM_CH          2    number of channels (1..8)
//   ADDR_WIDTH      32   byte address width
//   GRANULE_LSB     2    addr bits [GRANULE_LSB-1:0] ignored in matching (4-byte granule)
//   TIMEOUT_CYCLES  255  cycles a reservation survives; 0 = never expires
// PORTS
//   clock         in   1                    system clock
//   reset         in   1                    synchronous, active-high
//   flush         in   NUM_CH               per-channel exception/eret flush; clears that LLbit
//   ll_valid      in   NUM_CH               LL executing on channel i this cycle
//   ll_addr       in   NUM_CH*ADDR_WIDTH    LL address, channel i at [i*AW +: AW]
//   sc_valid      in   NUM_CH               SC executing on channel i
//   sc_addr       in   NUM_CH*ADDR_WIDTH    SC address
//   st_valid      in   NUM_CH               ordinary store committing on channel i
//   st_addr       in   NUM_CH*ADDR_WIDTH    store address
//   sc_success    out  NUM_CH               combinational SC grant; drives SC rt result + mem write enable
//   LLbit_output  out  NUM_CH               registered LLbit per channel
//   resv_addr     out  NUM_CH*ADDR_WIDTH    registered reserved address (granule bits as captured)
// BEHAVIOUR
//   Single clock domain; reset is synchronous and active-high.
//   Reset: LLbit_output=0, resv_addr=0, all counters=0; sc_success forced 0 while reset=1.
//   match(a,b) := a[AW-1:GRANULE_LSB]==b[AW-1:GRANULE_LSB].
//   sc_success[i] = sc_valid[i] & LLbit[i] & match(sc_addr[i],resv_addr[i]) & ~flush[i] & ~ll_valid[i]
//     & no st_valid[j], j!=i, with match(st_addr[j],sc_addr[i])   (same-cycle foreign store ordered first)
//     & no sc_success[j], j<i, to same granule   (lowest index wins same-granule SC race).
//   Per-channel next state, priority high->low:
//     1 reset            -> LLbit=0, cnt=0
//     2 flush[i]         -> LLbit=0, cnt=0 (resv_addr held)
//     3 ll_valid[i]      -> LLbit=1, resv_addr=ll_addr[i], cnt=0 (LL beats simultaneous SC/store/kill; SC on i fails)
//     4 sc_valid[i]      -> LLbit=0, cnt=0 (success or fail)
//     5 kill[i]          -> LLbit=0, cnt=0; kill[i] = any j!=i with (st_valid[j] | sc_success[j]) matching resv_addr[i]
//     6 expiry           -> TIMEOUT_CYCLES!=0 & LLbit & cnt==TIMEOUT_CYCLES-1 -> LLbit=0, cnt=0
//     7 LLbit=1          -> cnt=cnt+1; else cnt held 0
//   Own ordinary store (st_valid[i]) never clears LLbit[i].
//   Counter width $clog2(TIMEOUT_CYCLES+1); saturation impossible as expiry resets it.
//   LL latency: LLbit_output/resv_addr visible 1 cycle after ll_valid; SC in that next cycle can succeed.
//   SC sampling the cycle the expiry edge occurs sees LLbit=1 and succeeds.
//   Reset mid-reservation drops all reservations; no SC may succeed in the reset cycle.
// TESTING
//   1 ch0 LL 0x100, next cycle SC 0x100 -> sc_success[0]=1, LLbit_output[0]=0 after edge.
//   2 ch0 LL 0x100; ch1 store 0x102 -> LLbit[0]=0; ch0 SC 0x100 -> sc_success=0. Ch1 store 0x104 instead -> SC succeeds.
//   3 ch0,ch1 LL 0x200; same cycle both SC 0x200 -> sc_success=2'b01, both LLbits 0.
//   4 TIMEOUT_CYCLES=4: LL then idle; LLbit high exactly 4 cycles; SC in 4th cycle ok, 5th fails.
//   5 ch0 LL 0x300 then flush[0] -> LLbit=0, SC fails; LL+SC same cycle ch0 -> sc_success=0, LLbit=1.
//   6 reset asserted while ch0,ch1 reserved and SC pending -> sc_success=0, all outputs 0 next cycle.

Source files
------------

// File: rtl/llsc_monitor.sv
// llsc_monitor: multi-channel LL/SC reservation monitor with cross-channel kill and expiry
module llsc_monitor #(
    parameter int NUM_CH         = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int GRANULE_LSB    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            flush,
    input  logic [NUM_CH-1:0]            ll_valid,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ll_addr,
    input  logic [NUM_CH-1:0]            sc_valid,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] sc_addr,
    input  logic [NUM_CH-1:0]            st_valid,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] st_addr,
    output logic [NUM_CH-1:0]            sc_success,
    output logic [NUM_CH-1:0]            LLbit_output,
    output logic [NUM_CH*ADDR_WIDTH-1:0] resv_addr
);
    localparam int AW = ADDR_WIDTH;
    localparam int CW = TIMEOUT_CYCLES == 0 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

    logic [CW-1:0]     cnt [NUM_CH];
    logic [NUM_CH-1:0] kill;

    function automatic logic same(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return a[AW-1:GRANULE_LSB] == b[AW-1:GRANULE_LSB];
    endfunction

    // Grants resolve in index order so a lower channel wins a same-granule race.
    always_comb begin
        sc_success = '0;
        kill = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sc_success[i] = sc_valid[i] & LLbit_output[i] & ~flush[i] & ~ll_valid[i] & ~reset
                & same(sc_addr[i*AW +: AW], resv_addr[i*AW +: AW]);
            for (int j = 0; j < NUM_CH; j++)
                if (j != i && ((st_valid[j] && same(st_addr[j*AW +: AW], sc_addr[i*AW +: AW]))
                    || (j < i && sc_success[j] && same(sc_addr[j*AW +: AW], sc_addr[i*AW +: AW]))))
                    sc_success[i] = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++)
            for (int j = 0; j < NUM_CH; j++)
                if (j != i && ((st_valid[j] && same(st_addr[j*AW +: AW], resv_addr[i*AW +: AW]))
                    || (sc_success[j] && same(sc_addr[j*AW +: AW], resv_addr[i*AW +: AW]))))
                    kill[i] = 1'b1;
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                LLbit_output[i] <= 1'b0;
                resv_addr[i*AW +: AW] <= '0;
                cnt[i] <= '0;
            end else if (flush[i] || (!ll_valid[i] && (sc_valid[i] || kill[i]
                || (TIMEOUT_CYCLES != 0 && LLbit_output[i] && cnt[i] == LAST)))) begin
                LLbit_output[i] <= 1'b0;
                cnt[i] <= '0;
            end else if (ll_valid[i]) begin
                LLbit_output[i] <= 1'b1;
                resv_addr[i*AW +: AW] <= ll_addr[i*AW +: AW];
                cnt[i] <= '0;
            end else if (LLbit_output[i]) begin
                cnt[i] <= cnt[i] + CW'(1);
            end
        end
    end
endmodule
